// File: rtl/tmds_symbol_decoder.sv
// -----------------------------------------------------------------------------
// tmds_symbol_decoder
// Receive side of one HDMI TMDS channel. Raw 10-bit words from a 1:10
// deserializer arrive with an arbitrary bit phase. The block slides a 10-bit
// window across two consecutive words until runs of control tokens (sent
// during blanking) show up at a stable offset. It then freezes that offset
// and decodes every aligned symbol.
//
// Parameters
//   CHANNEL       TMDS channel index 0..2; selects the guard-band patterns
//   CTRL_RUN      consecutive control tokens at one offset needed to lock
//   SLIP_TIMEOUT  windows without a control token before the offset slips
//   LOCK_TIMEOUT  windows without a control token before lock is dropped
//
// Ports
//   clk_pixel    in   pixel clock, all logic on the rising edge
//   reset        in   synchronous, active-high
//   word_in      in   10 deserialized bits, bit 0 first on the wire
//   word_valid   in   word_in valid; when low every register holds
//   locked       out  symbol boundary found
//   bit_offset   out  current window offset 0..9
//   sym_valid    out  decoded outputs were updated this cycle
//   symbol       out  aligned raw symbol
//   data         out  video-decoded byte
//   ctrl         out  {c1,c0} when is_ctrl, else 0
//   terc4        out  TERC4 nibble when is_terc4, else 0
//   is_ctrl      out  symbol is one of the four control tokens
//   is_terc4     out  symbol is one of the sixteen TERC4 codes
//   is_video_gb  out  video guard band for this channel
//   is_di_gb     out  data-island guard band (channels 1 and 2 only)
// -----------------------------------------------------------------------------
module tmds_symbol_decoder #(
  parameter int CHANNEL      = 0,
  parameter int CTRL_RUN     = 8,
  parameter int SLIP_TIMEOUT = 2048,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [9:0] word_in,
  input  logic       word_valid,
  output logic       locked,
  output logic [3:0] bit_offset,
  output logic       sym_valid,
  output logic [9:0] symbol,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic [3:0] terc4,
  output logic       is_ctrl,
  output logic       is_terc4,
  output logic       is_video_gb,
  output logic       is_di_gb
);

  localparam int RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int MISS_W = $clog2(SLIP_TIMEOUT + 1);
  localparam int LTO_W  = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [9:0] DI_GB    = 10'b0100110011;
  localparam logic [9:0] VIDEO_GB = (CHANNEL == 1) ? 10'b0100110011 : 10'b1011001100;

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [9:0]          word_prev;
  logic [3:0]          offset_q, offset_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic [LTO_W-1:0]    lto_q, lto_d;

  logic [19:0]         cat;
  logic [9:0]          win;
  logic                win_ctrl_hit;
  logic [1:0]          win_ctrl_code;
  logic                win_terc4_hit;
  logic [3:0]          win_terc4_code;
  logic [7:0]          win_unflipped;
  logic [7:0]          win_data;

  // Offset 0 selects the previous word verbatim; larger offsets borrow the
  // low bits of the current word.
  assign cat = {word_in, word_prev};
  assign win = cat[offset_q +: 10];

  assign locked     = (state_q == LOCKED);
  assign bit_offset = offset_q;

  always_comb begin
    win_ctrl_hit  = 1'b1;
    win_ctrl_code = 2'b00;
    case (win)
      10'b1101010100: win_ctrl_code = 2'b00;
      10'b0010101011: win_ctrl_code = 2'b01;
      10'b0101010100: win_ctrl_code = 2'b10;
      10'b1010101011: win_ctrl_code = 2'b11;
      default:        win_ctrl_hit  = 1'b0;
    endcase
  end

  always_comb begin
    win_terc4_hit  = 1'b1;
    win_terc4_code = 4'h0;
    case (win)
      10'b1010011100: win_terc4_code = 4'h0;
      10'b1001100011: win_terc4_code = 4'h1;
      10'b1011100100: win_terc4_code = 4'h2;
      10'b1011100010: win_terc4_code = 4'h3;
      10'b0101110001: win_terc4_code = 4'h4;
      10'b0100011110: win_terc4_code = 4'h5;
      10'b0110001110: win_terc4_code = 4'h6;
      10'b0100111100: win_terc4_code = 4'h7;
      10'b1011001100: win_terc4_code = 4'h8;
      10'b0100111001: win_terc4_code = 4'h9;
      10'b0110011100: win_terc4_code = 4'hA;
      10'b1011000110: win_terc4_code = 4'hB;
      10'b1010001110: win_terc4_code = 4'hC;
      10'b1001110001: win_terc4_code = 4'hD;
      10'b0101100011: win_terc4_code = 4'hE;
      10'b1011000011: win_terc4_code = 4'hF;
      default:        win_terc4_hit  = 1'b0;
    endcase
  end

  // Video decode: undo the optional DC-balance inversion (bit 9), then undo
  // the XOR/XNOR transition chain selected by bit 8.
  always_comb begin
    win_unflipped = win[9] ? ~win[7:0] : win[7:0];
    win_data      = 8'h00;
    win_data[0]   = win_unflipped[0];
    for (int i = 1; i < 8; i++) begin
      win_data[i] = win[8] ? (win_unflipped[i] ^ win_unflipped[i-1])
                           : ~(win_unflipped[i] ^ win_unflipped[i-1]);
    end
  end

  // Alignment FSM. Only evaluated on valid words; the register block below
  // holds everything otherwise.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    run_d    = run_q;
    miss_d   = miss_q;
    lto_d    = lto_q;
    case (state_q)
      SEARCH: begin
        if (win_ctrl_hit) begin
          miss_d = '0;
          if (run_q == RUN_W'(CTRL_RUN - 1)) begin
            state_d = LOCKED;
            run_d   = '0;
            lto_d   = '0;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end else begin
          run_d = '0;
          if (miss_q == MISS_W'(SLIP_TIMEOUT - 1)) begin
            miss_d   = '0;
            offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
          end else begin
            miss_d = miss_q + MISS_W'(1);
          end
        end
      end
      LOCKED: begin
        if (win_ctrl_hit) begin
          lto_d = '0;
        end else if (lto_q == LTO_W'(LOCK_TIMEOUT - 1)) begin
          state_d = SEARCH;
          lto_d   = '0;
          run_d   = '0;
          miss_d  = '0;
        end else begin
          lto_d = lto_q + LTO_W'(1);
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q   <= SEARCH;
      offset_q  <= 4'd0;
      run_q     <= '0;
      miss_q    <= '0;
      lto_q     <= '0;
      word_prev <= 10'd0;
    end else if (word_valid) begin
      state_q   <= state_d;
      offset_q  <= offset_d;
      run_q     <= run_d;
      miss_q    <= miss_d;
      lto_q     <= lto_d;
      word_prev <= word_in;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      sym_valid   <= 1'b0;
      symbol      <= 10'd0;
      data        <= 8'h00;
      ctrl        <= 2'b00;
      terc4       <= 4'h0;
      is_ctrl     <= 1'b0;
      is_terc4    <= 1'b0;
      is_video_gb <= 1'b0;
      is_di_gb    <= 1'b0;
    end else begin
      sym_valid <= word_valid;
      if (word_valid) begin
        symbol      <= win;
        data        <= win_data;
        ctrl        <= win_ctrl_code;
        terc4       <= win_terc4_code;
        is_ctrl     <= win_ctrl_hit;
        is_terc4    <= win_terc4_hit;
        is_video_gb <= (win == VIDEO_GB);
        is_di_gb    <= (CHANNEL != 0) && (win == DI_GB);
      end
    end
  end

endmodule

// File: tb/tb_tmds_symbol_decoder.sv
// -----------------------------------------------------------------------------
// tb_tmds_symbol_decoder
// Two decoders (CHANNEL 0 and CHANNEL 1) share one stimulus stream. A model
// kept in the bench treats the input as a bit stream on the wire and derives
// the expected alignment and decode results; a compare process checks both
// instances against it every cycle, and directed checks pin known values.
// -----------------------------------------------------------------------------
module tb_tmds_symbol_decoder;

  localparam int CTRL_RUN = 8;
  localparam int SLIP     = 800;
  localparam int LOCKT    = 1000;

  localparam logic [9:0] TOK00  = 10'b1101010100;
  localparam logic [9:0] VID    = 10'b0101100011;
  localparam logic [9:0] VIDINV = 10'b1110011100;
  localparam logic [9:0] GB_A   = 10'b0100110011;
  localparam logic [9:0] GB_B   = 10'b1011001100;

  logic       clk_pixel = 1'b0;
  logic       reset;
  logic [9:0] word_in;
  logic       word_valid;

  logic       locked_c0, sym_valid_c0, is_ctrl_c0, is_terc4_c0, is_video_gb_c0, is_di_gb_c0;
  logic [3:0] bit_offset_c0, terc4_c0;
  logic [9:0] symbol_c0;
  logic [7:0] data_c0;
  logic [1:0] ctrl_c0;

  logic       locked_c1, sym_valid_c1, is_ctrl_c1, is_terc4_c1, is_video_gb_c1, is_di_gb_c1;
  logic [3:0] bit_offset_c1, terc4_c1;
  logic [9:0] symbol_c1;
  logic [7:0] data_c1;
  logic [1:0] ctrl_c1;

  int passes = 0;
  int checks = 0;

  always #5 clk_pixel = ~clk_pixel;

  tmds_symbol_decoder #(
    .CHANNEL(0), .CTRL_RUN(CTRL_RUN), .SLIP_TIMEOUT(SLIP), .LOCK_TIMEOUT(LOCKT)
  ) dut_c0 (
    .clk_pixel(clk_pixel), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .locked(locked_c0), .bit_offset(bit_offset_c0), .sym_valid(sym_valid_c0),
    .symbol(symbol_c0), .data(data_c0), .ctrl(ctrl_c0), .terc4(terc4_c0),
    .is_ctrl(is_ctrl_c0), .is_terc4(is_terc4_c0),
    .is_video_gb(is_video_gb_c0), .is_di_gb(is_di_gb_c0)
  );

  tmds_symbol_decoder #(
    .CHANNEL(1), .CTRL_RUN(CTRL_RUN), .SLIP_TIMEOUT(SLIP), .LOCK_TIMEOUT(LOCKT)
  ) dut_c1 (
    .clk_pixel(clk_pixel), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .locked(locked_c1), .bit_offset(bit_offset_c1), .sym_valid(sym_valid_c1),
    .symbol(symbol_c1), .data(data_c1), .ctrl(ctrl_c1), .terc4(terc4_c1),
    .is_ctrl(is_ctrl_c1), .is_terc4(is_terc4_c1),
    .is_video_gb(is_video_gb_c1), .is_di_gb(is_di_gb_c1)
  );

  // Code tables, indexed by the value each symbol carries.
  logic [9:0] ctrl_tab [4] = '{10'b1101010100, 10'b0010101011,
                               10'b0101010100, 10'b1010101011};
  logic [9:0] terc4_tab [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  // Model expectations
  bit         model_ready = 1'b0;
  logic [9:0] m_prev;
  logic [3:0] m_off;
  logic       m_lock;
  int         m_run, m_miss, m_lto;
  logic       exp_sv, exp_isc, exp_ist, exp_vgb0, exp_dig0, exp_vgb1, exp_dig1;
  logic [9:0] exp_sym;
  logic [7:0] exp_data;
  logic [1:0] exp_ctrl;
  logic [3:0] exp_terc4;

  // The model decodes by running the TMDS transition encoder forwards on every
  // candidate byte and picking the one whose chain matches the symbol.
  function automatic logic [7:0] videoByte(input logic [9:0] s);
    logic [7:0] target, q, d;
    target = s[9] ? ~s[7:0] : s[7:0];
    for (int v = 0; v < 256; v++) begin
      d = v[7:0];
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = s[8] ? (q[i-1] ^ d[i]) : ~(q[i-1] ^ d[i]);
      if (q == target) return d;
    end
    return 8'h00;
  endfunction

  always @(posedge clk_pixel) begin
    if (reset) begin
      model_ready = 1'b1;
      m_prev = '0; m_off = '0; m_lock = 1'b0; m_run = 0; m_miss = 0; m_lto = 0;
      exp_sv = 0; exp_sym = '0; exp_data = '0; exp_ctrl = '0; exp_terc4 = '0;
      exp_isc = 0; exp_ist = 0; exp_vgb0 = 0; exp_dig0 = 0; exp_vgb1 = 0; exp_dig1 = 0;
    end else if (model_ready) begin
      exp_sv = word_valid;
      if (word_valid) begin
        logic [9:0] w;
        logic       hit_c;
        for (int b = 0; b < 10; b++) begin
          int p;
          p = int'(m_off) + b;
          w[b] = (p < 10) ? m_prev[p] : word_in[p-10];
        end
        hit_c = 1'b0; exp_ctrl = 2'b00;
        for (int k = 0; k < 4; k++) if (ctrl_tab[k] == w) begin hit_c = 1'b1; exp_ctrl = 2'(k); end
        exp_ist = 1'b0; exp_terc4 = 4'h0;
        for (int k = 0; k < 16; k++) if (terc4_tab[k] == w) begin exp_ist = 1'b1; exp_terc4 = 4'(k); end
        exp_isc  = hit_c;
        exp_sym  = w;
        exp_data = videoByte(w);
        exp_vgb0 = (w == GB_B);
        exp_dig0 = 1'b0;
        exp_vgb1 = (w == GB_A);
        exp_dig1 = (w == GB_A);
        if (!m_lock) begin
          if (hit_c) begin
            m_run++; m_miss = 0;
            if (m_run == CTRL_RUN) begin m_lock = 1'b1; m_run = 0; m_lto = 0; end
          end else begin
            m_run = 0; m_miss++;
            if (m_miss == SLIP) begin m_off = 4'((int'(m_off) + 1) % 10); m_miss = 0; end
          end
        end else begin
          if (hit_c) m_lto = 0;
          else begin
            m_lto++;
            if (m_lto == LOCKT) begin m_lock = 1'b0; m_run = 0; m_lto = 0; end
          end
        end
        m_prev = word_in;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  always @(negedge clk_pixel) begin
    if (model_ready) begin
      checkOutput("c0_state", {locked_c0, bit_offset_c0, sym_valid_c0}, {m_lock, m_off, exp_sv});
      checkOutput("c1_state", {locked_c1, bit_offset_c1, sym_valid_c1}, {m_lock, m_off, exp_sv});
      checkOutput("c0_decode", {symbol_c0, data_c0, ctrl_c0, terc4_c0, is_ctrl_c0, is_terc4_c0},
                  {exp_sym, exp_data, exp_ctrl, exp_terc4, exp_isc, exp_ist});
      checkOutput("c1_decode", {symbol_c1, data_c1, ctrl_c1, terc4_c1, is_ctrl_c1, is_terc4_c1},
                  {exp_sym, exp_data, exp_ctrl, exp_terc4, exp_isc, exp_ist});
      checkOutput("c0_gb", {is_video_gb_c0, is_di_gb_c0}, {exp_vgb0, exp_dig0});
      checkOutput("c1_gb", {is_video_gb_c1, is_di_gb_c1}, {exp_vgb1, exp_dig1});
    end
  end

  task automatic applyStimulus(input logic [9:0] w, input logic v);
    @(negedge clk_pixel);
    word_in    = w;
    word_valid = v;
  endtask

  task automatic afterEdge();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk_pixel);
    reset = 1'b1; word_valid = 1'b0; word_in = '0;
    @(negedge clk_pixel);
    reset = 1'b0;
  endtask

  // Aligned token stream with a three-cycle valid gap after the 4th token.
  task automatic alignedRun();
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(TOK00, 1'b1);
      if (i == 4) repeat (3) applyStimulus(10'h3FF, 1'b0);
      if (i == 8) begin
        afterEdge();
        checkOutput("lit_run7_unlocked", locked_c1, 0);
      end
      if (i == 9) begin
        afterEdge();
        checkOutput("lit_run8_locked", locked_c1, 1);
        checkOutput("lit_run8_ctrl", {is_ctrl_c1, ctrl_c1, bit_offset_c1}, {1'b1, 2'b00, 4'd0});
      end
    end
  endtask

  bit bitq[$];

  task automatic pushSym(input logic [9:0] s);
    logic [9:0] w;
    for (int b = 0; b < 10; b++) bitq.push_back(s[b]);
    while (bitq.size() >= 10) begin
      for (int b = 0; b < 10; b++) w[b] = bitq.pop_front();
      applyStimulus(w, 1'b1);
    end
  endtask

  // Blanking runs plus active video, shifted on the wire by r bits.
  task automatic rotatedRun(input int r, input int lines);
    bitq.delete();
    for (int b = 0; b < r; b++) bitq.push_back(1'b0);
    for (int l = 0; l < lines; l++) begin
      for (int j = 0; j < 16; j++) pushSym(TOK00);
      for (int j = 0; j < 720; j++) pushSym(VID);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] syms [25];
    reset = 1'b1; word_valid = 1'b0; word_in = '0;
    doReset();
    checkOutput("lit_reset", {locked_c1, bit_offset_c1, sym_valid_c1, symbol_c1}, 16'd0);
    checkOutput("lit_model_a5", videoByte(VID), 8'hA5);
    checkOutput("lit_model_a5_inv", videoByte(VIDINV), 8'hA5);

    alignedRun();

    syms[0] = GB_A; syms[1] = GB_B;
    for (int k = 0; k < 16; k++) syms[2+k] = terc4_tab[k];
    syms[18] = 10'b0010101011; syms[19] = 10'b0101010100; syms[20] = 10'b1010101011;
    syms[21] = VID; syms[22] = VIDINV; syms[23] = TOK00; syms[24] = TOK00;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(syms[i], 1'b1);
      afterEdge();
      if (i == 1) begin
        checkOutput("lit_gb_di_c1", {is_video_gb_c1, is_di_gb_c1}, 2'b11);
        checkOutput("lit_gb_di_c0", {is_video_gb_c0, is_di_gb_c0}, 2'b00);
      end
      if (i == 2) begin
        checkOutput("lit_gb_vid_c0", {is_video_gb_c0, is_di_gb_c0, is_terc4_c0, terc4_c0}, {3'b101, 4'h8});
        checkOutput("lit_gb_vid_c1", {is_video_gb_c1, is_di_gb_c1}, 2'b00);
      end
      if (i == 3)  checkOutput("lit_terc4_0", {is_terc4_c1, terc4_c1}, {1'b1, 4'h0});
      if (i == 18) checkOutput("lit_terc4_15", {is_terc4_c1, terc4_c1}, {1'b1, 4'hF});
      if (i == 19) checkOutput("lit_ctrl_01", {is_ctrl_c1, ctrl_c1}, {1'b1, 2'b01});
      if (i == 22) checkOutput("lit_video_a5", data_c1, 8'hA5);
      if (i == 23) checkOutput("lit_video_inv_a5", {is_ctrl_c1, data_c1}, {1'b0, 8'hA5});
    end

    for (int i = 1; i <= LOCKT + 1; i++) begin
      applyStimulus(VID, 1'b1);
      if (i == LOCKT) begin
        afterEdge();
        checkOutput("lit_timeout_minus1", locked_c1, 1);
      end
      if (i == LOCKT + 1) begin
        afterEdge();
        checkOutput("lit_timeout_drop", locked_c1, 0);
      end
    end

    doReset();
    rotatedRun(3, 5);
    afterEdge();
    checkOutput("lit_rot3_lock", {locked_c1, bit_offset_c1, data_c1}, {1'b1, 4'd3, 8'hA5});

    doReset();
    rotatedRun(5, 7);
    afterEdge();
    checkOutput("lit_rot5_lock", {locked_c1, bit_offset_c1}, {1'b1, 4'd5});
    doReset();
    checkOutput("lit_reset_locked", {locked_c1, bit_offset_c1}, {1'b0, 4'd0});
    alignedRun();

    applyStimulus(TOK00, 1'b0);
    afterEdge();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
